// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM bus arbiter: default bus widths, FSM state
// encodings, requester IDs and the grant selection helper.
package sdram_arb_pkg;

    localparam int ARB_ADDR_BITS = 24;
    localparam int ARB_DATA_BITS = 32;
    localparam int NUM_REQ       = 3;

    typedef logic [1:0] req_id_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam req_id_t REQ_D  = 2'd0;
    localparam req_id_t REQ_I  = 2'd1;
    localparam req_id_t REQ_MU = 2'd2;

    // Scan the requesters starting just after 'prev' in D -> I -> MU order.
    // Passing REQ_MU as 'prev' yields plain fixed priority D > I > MU.
    function automatic req_id_t arb_pick(input logic [2:0] pend, input req_id_t prev);
        req_id_t pick;
        logic    found;
        int      cand;
        pick  = REQ_D;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(prev) + k) % NUM_REQ;
            if (!found && pend[cand]) begin
                pick  = req_id_t'(cand);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sdram_bus_arbiter_if.sv
// One SDRAM-style request/response bus. The same shape serves the three
// requester ports and the controller port; 'master' is the side that issues.
interface sdram_bus_arbiter_if #(
    parameter int ADDR_BITS = 24,
    parameter int DATA_BITS = 32
);
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data;
    logic                 we;
    logic                 start;
    logic [DATA_BITS-1:0] q;
    logic                 done;
    logic                 ready;

    modport master (output addr, data, we, start, input q, done, ready);
    modport slave  (input addr, data, we, start, output q, done, ready);
endinterface

// File: rtl/sdram_arb_req_slot.sv
// Per-requester slot: captures a request on start&&ready, holds it pending
// until the arbiter finishes it, then returns q with a one-cycle done pulse.
module sdram_arb_req_slot #(
    parameter int ADDR_BITS = 24,
    parameter int DATA_BITS = 32
) (
    input  logic                 clk100,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 we,
    input  logic                 fin,
    input  logic [DATA_BITS-1:0] fin_q,
    output logic                 pending,
    output logic                 ready,
    output logic [ADDR_BITS-1:0] lat_addr,
    output logic [DATA_BITS-1:0] lat_data,
    output logic                 lat_we,
    output logic [DATA_BITS-1:0] q,
    output logic                 done
);

    // Capture, completion and registered ready (always the inverse of the next pending).
    always_ff @(posedge clk100) begin
        if (reset) begin
            pending  <= 1'b0;
            ready    <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_we   <= 1'b0;
            q        <= '0;
            done     <= 1'b0;
        end else begin
            done <= fin && pending;
            if (fin && pending) begin
                pending <= 1'b0;
                ready   <= 1'b1;
                q       <= fin_q;
            end else if (start && ready) begin
                pending  <= 1'b1;
                ready    <= 1'b0;
                lat_addr <= addr;
                lat_data <= data;
                lat_we   <= we;
            end else begin
                ready <= !pending;
            end
        end
    end

endmodule

// File: rtl/sdram_bus_arbiter.sv
// Shares one SDRAM controller port between the I-cache, D-cache and Memory
// Unit. One transaction is in flight at a time; the result is routed back to
// the requester that owns it.
// Build option: define SDRAM_ARB_RR_EN for round-robin grants (D -> I -> MU
// rotation, last winner lowest); otherwise fixed priority D > I > MU.
module sdram_bus_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_BITS = ARB_ADDR_BITS,
    parameter int DATA_BITS = ARB_DATA_BITS
) (
    input  logic                        clk100,
    input  logic                        reset,
    sdram_bus_arbiter_if.slave          bus_i_sdram,
    sdram_bus_arbiter_if.slave          bus_d_sdram,
    sdram_bus_arbiter_if.slave          bus_mu,
    sdram_bus_arbiter_if.master         sdram
);

    logic [1:0]           state;
    req_id_t              grant;
    req_id_t              win;
    req_id_t              prio_last;
    logic                 issue;
    logic [NUM_REQ-1:0]   pend;
    logic [NUM_REQ-1:0]   fin;
    logic [NUM_REQ-1:0]   s_we;
    logic [ADDR_BITS-1:0] s_addr [NUM_REQ];
    logic [DATA_BITS-1:0] s_data [NUM_REQ];

    // The instruction port is read-only; its data/we inputs are never used.
    logic unused_i_bus;
    assign unused_i_bus = ^{bus_i_sdram.data, bus_i_sdram.we};

    sdram_arb_req_slot #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) u_slot_d (
        .clk100   (clk100),
        .reset    (reset),
        .start    (bus_d_sdram.start),
        .addr     (bus_d_sdram.addr),
        .data     (bus_d_sdram.data),
        .we       (bus_d_sdram.we),
        .fin      (fin[REQ_D]),
        .fin_q    (sdram.q),
        .pending  (pend[REQ_D]),
        .ready    (bus_d_sdram.ready),
        .lat_addr (s_addr[REQ_D]),
        .lat_data (s_data[REQ_D]),
        .lat_we   (s_we[REQ_D]),
        .q        (bus_d_sdram.q),
        .done     (bus_d_sdram.done)
    );

    sdram_arb_req_slot #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) u_slot_i (
        .clk100   (clk100),
        .reset    (reset),
        .start    (bus_i_sdram.start),
        .addr     (bus_i_sdram.addr),
        .data     ('0),
        .we       (1'b0),
        .fin      (fin[REQ_I]),
        .fin_q    (sdram.q),
        .pending  (pend[REQ_I]),
        .ready    (bus_i_sdram.ready),
        .lat_addr (s_addr[REQ_I]),
        .lat_data (s_data[REQ_I]),
        .lat_we   (s_we[REQ_I]),
        .q        (bus_i_sdram.q),
        .done     (bus_i_sdram.done)
    );

    sdram_arb_req_slot #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) u_slot_mu (
        .clk100   (clk100),
        .reset    (reset),
        .start    (bus_mu.start),
        .addr     (bus_mu.addr),
        .data     (bus_mu.data),
        .we       (bus_mu.we),
        .fin      (fin[REQ_MU]),
        .fin_q    (sdram.q),
        .pending  (pend[REQ_MU]),
        .ready    (bus_mu.ready),
        .lat_addr (s_addr[REQ_MU]),
        .lat_data (s_data[REQ_MU]),
        .lat_we   (s_we[REQ_MU]),
        .q        (bus_mu.q),
        .done     (bus_mu.done)
    );

    assign win   = arb_pick(pend, prio_last);
    assign issue = (state == ST_IDLE) && sdram.ready && (|pend);

`ifdef SDRAM_ARB_RR_EN
    req_id_t last_grant;

    // Remember the latest winner so it drops to lowest priority next time.
    always_ff @(posedge clk100) begin
        if (reset) begin
            last_grant <= REQ_MU;
        end else if (issue) begin
            last_grant <= win;
        end
    end

    assign prio_last = last_grant;
`else
    assign prio_last = REQ_MU;
`endif

    // Completion strobe for the granted slot; done outside WAIT is ignored.
    always_comb begin
        fin = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            fin[r] = (state == ST_WAIT) && sdram.done && (grant == req_id_t'(r));
        end
    end

    // Transaction FSM: grant and register the request, pulse start, wait for done.
    always_ff @(posedge clk100) begin
        if (reset) begin
            state       <= ST_IDLE;
            grant       <= REQ_D;
            sdram.addr  <= '0;
            sdram.data  <= '0;
            sdram.we    <= 1'b0;
            sdram.start <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        grant       <= win;
                        sdram.addr  <= s_addr[win];
                        sdram.data  <= s_data[win];
                        sdram.we    <= s_we[win];
                        sdram.start <= 1'b1;
                        state       <= ST_ISSUE;
                    end else begin
                        sdram.start <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    sdram.start <= 1'b0;
                    state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    sdram.start <= 1'b0;
                    if (sdram.done) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    sdram.start <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_bus_arbiter.sv
// Bench for sdram_bus_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model of the three requesters and
// the shared controller. Honours SDRAM_ARB_RR_EN for the expected grant order.
module tb_sdram_bus_arbiter;
    import sdram_arb_pkg::*;

    localparam int AB = 24;
    localparam int DB = 32;
`ifdef SDRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk100 = 1'b0;
    logic reset  = 1'b1;
    always #5 clk100 = ~clk100;

    sdram_bus_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus_i_sdram ();
    sdram_bus_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus_d_sdram ();
    sdram_bus_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus_mu ();
    sdram_bus_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) sdram ();

    sdram_bus_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk100      (clk100),
        .reset       (reset),
        .bus_i_sdram (bus_i_sdram),
        .bus_d_sdram (bus_d_sdram),
        .bus_mu      (bus_mu),
        .sdram       (sdram)
    );

    // Stimulus (index 0 = D, 1 = I, 2 = MU)
    bit          d_start [3];
    logic [23:0] d_addr  [3];
    logic [31:0] d_data  [3];
    bit          d_we    [3];
    logic        d_sready = 1'b1;
    logic        d_sdone  = 1'b0;
    logic [31:0] d_sq     = '0;

    // Reference model
    bit          m_pend  [3];
    bit          m_ready [3];
    bit          m_done  [3];
    logic [31:0] m_q     [3];
    logic [23:0] l_addr  [3];
    logic [31:0] l_data  [3];
    bit          l_we    [3];
    bit          m_busy;
    int          m_fid;
    int          m_last = 2;
    bit          m_sstart;
    logic [23:0] m_saddr;
    logic [31:0] m_sdata;
    bit          m_swe;

    // Controller model
    bit          mem_busy;
    int          mem_cnt;
    int          mem_lat = 1;
    logic [31:0] mem_q;
    bit          q_ov;
    logic [31:0] ov_val;
    bit          rnd_ready;
    bit          rnd_lat;

    // Observation logs and counters
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cnt;
    int          start_cyc;
    int          viol_cnt = 0;
    int          done_cnt [3];
    logic [23:0] obs_addr [$];
    logic [31:0] obs_data [$];
    logic        obs_we   [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic obs_ready(input int r);
        case (r)
            0:       return bus_d_sdram.ready;
            1:       return bus_i_sdram.ready;
            default: return bus_mu.ready;
        endcase
    endfunction

    function automatic logic obs_done(input int r);
        case (r)
            0:       return bus_d_sdram.done;
            1:       return bus_i_sdram.done;
            default: return bus_mu.done;
        endcase
    endfunction

    function automatic logic [31:0] obs_q(input int r);
        case (r)
            0:       return bus_d_sdram.q;
            1:       return bus_i_sdram.q;
            default: return bus_mu.q;
        endcase
    endfunction

    // Winner among pending requesters: D, I, MU order, starting after the
    // last winner when round-robin is built in.
    function automatic int exp_winner();
        int first;
        first = RR ? (m_last + 1) % 3 : 0;
        for (int k = 0; k < 3; k++) begin
            if (m_pend[(first + k) % 3]) return (first + k) % 3;
        end
        return 0;
    endfunction

    task automatic drive();
        bus_d_sdram.start = d_start[0];
        bus_d_sdram.addr  = d_addr[0];
        bus_d_sdram.data  = d_data[0];
        bus_d_sdram.we    = d_we[0];
        bus_i_sdram.start = d_start[1];
        bus_i_sdram.addr  = d_addr[1];
        bus_i_sdram.data  = '0;
        bus_i_sdram.we    = 1'b0;
        bus_mu.start      = d_start[2];
        bus_mu.addr       = d_addr[2];
        bus_mu.data       = d_data[2];
        bus_mu.we         = d_we[2];
        sdram.ready       = d_sready;
        sdram.done        = d_sdone;
        sdram.q           = d_sq;
    endtask

    task automatic model_edge();
        bit old_busy;
        int w;
        if (reset) begin
            for (int r = 0; r < 3; r++) begin
                m_pend[r] = 0; m_ready[r] = 0; m_done[r] = 0; m_q[r] = '0;
            end
            m_busy = 0; m_last = 2;
            m_sstart = 0; m_saddr = '0; m_sdata = '0; m_swe = 0;
            return;
        end
        old_busy = m_busy;
        m_sstart = 0;
        if (!old_busy && d_sready && (m_pend[0] || m_pend[1] || m_pend[2])) begin
            w = exp_winner();
            m_sstart = 1; m_saddr = l_addr[w]; m_sdata = l_data[w]; m_swe = l_we[w];
            m_busy = 1; m_fid = w; m_last = w;
        end
        for (int r = 0; r < 3; r++) m_done[r] = 0;
        if (old_busy && d_sdone) begin
            m_done[m_fid] = 1; m_q[m_fid] = d_sq; m_pend[m_fid] = 0; m_busy = 0;
        end
        for (int r = 0; r < 3; r++) begin
            if (d_start[r]) begin
                if (m_ready[r]) begin
                    m_pend[r] = 1;
                    l_addr[r] = d_addr[r];
                    l_data[r] = (r == 1) ? 32'h0 : d_data[r];
                    l_we[r]   = (r == 1) ? 1'b0 : d_we[r];
                end else begin
                    viol_cnt++;
                end
            end
        end
        for (int r = 0; r < 3; r++) m_ready[r] = !m_pend[r];
    endtask

    task automatic compare();
        string nm [3] = '{"d", "i", "mu"};
        for (int r = 0; r < 3; r++) begin
            chk({"ready_", nm[r]}, 64'(obs_ready(r)), 64'(m_ready[r]));
            chk({"done_", nm[r]},  64'(obs_done(r)),  64'(m_done[r]));
            chk({"q_", nm[r]},     64'(obs_q(r)),     64'(m_q[r]));
        end
        chk("sdram_start", 64'(sdram.start), 64'(m_sstart));
        chk("sdram_addr",  64'(sdram.addr),  64'(m_saddr));
        chk("sdram_data",  64'(sdram.data),  64'(m_sdata));
        chk("sdram_we",    64'(sdram.we),    64'(m_swe));
    endtask

    task automatic observe();
        if (sdram.start === 1'b1) begin
            start_cnt++;
            start_cyc = cyc;
            obs_addr.push_back(sdram.addr);
            obs_data.push_back(sdram.data);
            obs_we.push_back(sdram.we);
        end
        for (int r = 0; r < 3; r++) if (obs_done(r) === 1'b1) done_cnt[r]++;
        d_sdone = 1'b0;
        d_sq    = $urandom;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                d_sdone  = 1'b1;
                d_sq     = mem_q;
                mem_busy = 0;
            end
        end
        if (sdram.start === 1'b1 && !mem_busy) begin
            mem_busy = 1;
            mem_cnt  = rnd_lat ? $urandom_range(1, 5) : mem_lat;
            mem_q    = q_ov ? ov_val : $urandom;
        end
        if (mem_busy || d_sdone) d_sready = 1'b0;
        else d_sready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic tick();
        drive();
        @(posedge clk100);
        model_edge();
        #1;
        cyc++;
        compare();
        observe();
        for (int r = 0; r < 3; r++) d_start[r] = 0;
    endtask

    task automatic clear_logs();
        start_cnt = 0;
        for (int r = 0; r < 3; r++) done_cnt[r] = 0;
        obs_addr.delete();
        obs_data.delete();
        obs_we.delete();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((m_busy || m_pend[0] || m_pend[1] || m_pend[2] || mem_busy) && n < 300) begin
            tick();
            n++;
        end
        chk(tag, 64'(n < 300), 64'd1);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int req_cyc;
        int n;
        int mu_cnt;
        for (int r = 0; r < 3; r++) begin
            d_start[r] = 0; d_addr[r] = '0; d_data[r] = '0; d_we[r] = 0;
        end

        // Reset for 3 cycles: model expects all-zero outputs, then ready=1.
        clear_logs();
        do_reset(3);
        chk("ready_d_after_reset",  64'(bus_d_sdram.ready), 64'd1);
        chk("ready_i_after_reset",  64'(bus_i_sdram.ready), 64'd1);
        chk("ready_mu_after_reset", 64'(bus_mu.ready),      64'd1);
        chk("start_after_reset",    64'(sdram.start),       64'd0);

        // Single I read through a 1-cycle memory.
        clear_logs();
        q_ov = 1; ov_val = 32'hDEADBEEF; mem_lat = 1;
        d_start[1] = 1; d_addr[1] = 24'h000010;
        tick();
        req_cyc = cyc;
        drain("i_read_timeout");
        chk("i_read_starts",  64'(start_cnt), 64'd1);
        chk("i_read_addr",    64'(obs_addr[0]), 64'h000010);
        chk("i_read_we",      64'(obs_we[0]), 64'd0);
        chk("i_read_latency", 64'(start_cyc - req_cyc), 64'd1);
        chk("i_read_done",    64'(done_cnt[1]), 64'd1);
        chk("i_read_q",       64'(bus_i_sdram.q), 64'hDEADBEEF);
        chk("i_read_d_quiet", 64'(done_cnt[0] + done_cnt[2]), 64'd0);
        q_ov = 0;

        // D write and I read launched together: D goes first.
        clear_logs();
        d_start[0] = 1; d_addr[0] = 24'h000100; d_data[0] = 32'h12345678; d_we[0] = 1;
        d_start[1] = 1; d_addr[1] = 24'h000004;
        tick();
        drain("di_timeout");
        chk("di_starts",  64'(start_cnt), 64'd2);
        chk("di_first",   64'(obs_addr[0]), 64'h000100);
        chk("di_first_we", 64'(obs_we[0]), 64'd1);
        chk("di_first_data", 64'(obs_data[0]), 64'h12345678);
        chk("di_second",  64'(obs_addr[1]), 64'h000004);
        chk("di_second_we", 64'(obs_we[1]), 64'd0);
        chk("di_done_d",  64'(done_cnt[0]), 64'd1);
        chk("di_done_i",  64'(done_cnt[1]), 64'd1);

        // All three requesters restart as soon as they are free.
        do_reset(2);
        clear_logs();
        n = 0;
        while (start_cnt < 9 && n < 200) begin
            for (int r = 0; r < 3; r++) begin
                if (m_ready[r]) begin
                    d_start[r] = 1;
                    d_addr[r]  = 24'((r + 1) << 8) | 24'(n & 8'hFF);
                    d_data[r]  = $urandom;
                    d_we[r]    = 1'($urandom_range(0, 1));
                end
            end
            tick();
            n++;
        end
        chk("greedy_timeout", 64'(start_cnt >= 9), 64'd1);
        drain("greedy_drain");
        mu_cnt = 0;
        for (int k = 0; k < 9; k++) begin
            if (obs_addr[k][11:8] == 4'h3) mu_cnt++;
`ifdef SDRAM_ARB_RR_EN
            chk("rr_order", 64'(obs_addr[k][11:8]), 64'((k % 3) + 1));
`else
            chk("fixed_order", 64'(obs_addr[k][11:8]), 64'((k % 2) + 1));
`endif
        end
`ifdef SDRAM_ARB_RR_EN
        chk("rr_mu_grants", 64'(mu_cnt), 64'd3);
`else
        chk("fixed_mu_starved", 64'(mu_cnt), 64'd0);
`endif

        // Reset while waiting for the controller; its late done is ignored.
        clear_logs();
        mem_lat = 4;
        d_start[0] = 1; d_addr[0] = 24'h000040; d_we[0] = 0;
        tick();
        n = 0;
        while (start_cnt == 0 && n < 10) begin tick(); n++; end
        chk("wait_reset_issue", 64'(start_cnt), 64'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (6) tick();
        chk("wait_reset_no_done", 64'(done_cnt[0] + done_cnt[1] + done_cnt[2]), 64'd0);
        chk("wait_reset_no_reissue", 64'(start_cnt), 64'd1);
        chk("wait_reset_ready_d", 64'(bus_d_sdram.ready), 64'd1);
        mem_lat = 1;
        d_start[2] = 1; d_addr[2] = 24'h000777; d_data[2] = 32'hCAFE0001; d_we[2] = 1;
        tick();
        drain("after_reset_timeout");
        chk("after_reset_mu_done", 64'(done_cnt[2]), 64'd1);
        chk("after_reset_addr", 64'(obs_addr[1]), 64'h000777);

        // Start while not ready: the second request must be dropped.
        clear_logs();
        n = viol_cnt;
        mem_lat = 3;
        d_start[0] = 1; d_addr[0] = 24'h000500; d_we[0] = 0;
        tick();
        d_start[0] = 1; d_addr[0] = 24'h000600; d_we[0] = 1;
        tick();
        drain("viol_timeout");
        chk("viol_flagged", 64'(viol_cnt - n), 64'd1);
        chk("viol_one_txn", 64'(start_cnt), 64'd1);
        chk("viol_addr",    64'(obs_addr[0]), 64'h000500);

        // Random traffic with random controller latency and readiness.
        clear_logs();
        n = viol_cnt;
        rnd_ready = 1; rnd_lat = 1;
        for (int c = 0; c < 1500; c++) begin
            for (int r = 0; r < 3; r++) begin
                if (m_ready[r] && $urandom_range(0, 2) == 0) begin
                    d_start[r] = 1;
                    d_addr[r]  = 24'($urandom);
                    d_data[r]  = $urandom;
                    d_we[r]    = 1'($urandom_range(0, 1));
                end
            end
            tick();
        end
        drain("random_drain");
        chk("random_no_viol", 64'(viol_cnt - n), 64'd0);
        chk("random_all_done", 64'(done_cnt[0] + done_cnt[1] + done_cnt[2]), 64'(start_cnt));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_bus_arbiter.md
Name: sdram_bus_arbiter

Overview:
- Shares the single SDRAM controller port between three requesters: L1 instruction cache (read-only), L1 data cache (read/write) and the Memory Unit (read/write).
- Sits between the CPU-side buses (bus_i_sdram_*, bus_d_sdram_*, bus_mu_*) and the SDRAM controller.
- Captures single-cycle start pulses, arbitrates, issues one transaction at a time and routes q/done back to the owning requester.

Parameters:
- ADDR_BITS, 24, word address width on all ports
- DATA_BITS, 32, data width on all ports

Ports:
- clk100  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- bus_i_sdram_addr  in  ADDR_BITS  instruction read address
- bus_i_sdram_start  in  1  instruction request pulse
- bus_i_sdram_q  out  DATA_BITS  instruction read data
- bus_i_sdram_done  out  1  instruction completion pulse
- bus_i_sdram_ready  out  1  instruction slot free
- bus_d_sdram_addr / bus_d_sdram_data / bus_d_sdram_we / bus_d_sdram_start  in  ADDR_BITS/DATA_BITS/1/1  data request
- bus_d_sdram_q / bus_d_sdram_done / bus_d_sdram_ready  out  DATA_BITS/1/1  data response
- bus_mu_addr / bus_mu_data / bus_mu_we / bus_mu_start  in  ADDR_BITS/DATA_BITS/1/1  Memory Unit request
- bus_mu_q / bus_mu_done / bus_mu_ready  out  DATA_BITS/1/1  Memory Unit response
- sdram_addr / sdram_data / sdram_we / sdram_start  out  ADDR_BITS/DATA_BITS/1/1  controller request
- sdram_q / sdram_done / sdram_ready  in  DATA_BITS/1/1  controller response

Behaviour:
- Reset: every output is 0; all pending flags are cleared; FSM goes to IDLE. An in-flight transaction is abandoned and its late sdram_done is ignored, because the controller shares this reset.
- Per-requester slot:
  - On an edge where start=1 and ready=1, latch addr, data and we (we forced 0 for I), then set pending.
  - ready is registered and equals !pending. It goes to 1 on the first cycle after reset is released.
  - A start while ready=0 is ignored; this is a protocol violation flagged by bench assertions.
- FSM IDLE:
  - If sdram_ready=1 and any slot is pending, select a grant, register sdram_addr/data/we from that slot, set sdram_start=1 and go to ISSUE.
  - Otherwise hold, with sdram_start=0.
- FSM ISSUE: sdram_start returns to 0 (start is exactly one cycle wide); go to WAIT.
- FSM WAIT:
  - On sdram_done=1, copy sdram_q to the granted requester's q register and pulse its done for exactly one cycle.
  - In the same edge, clear its pending (ready returns to 1 together with done) and go to IDLE.
  - Other requesters' outputs are unchanged.
- Latency (unloaded): requester start sampled at edge N → sdram_start high after edge N+1 → controller done sampled at edge M → requester done/q valid after edge M.
- q holds its value until the next done for the same requester. Writes also return sdram_q; requesters ignore it.
- Simultaneous events:
  - Several slots may be pending at once; exactly one is granted per transaction.
  - A new start accepted in the same edge that IDLE makes a grant is considered from the next arbitration onward.
  - sdram_done seen outside WAIT is ignored.
- Fixed priority (default): D > I > MU. MU may starve under continuous D/I traffic; this is accepted.

Optional Feature:
- SDRAM_ARB_RR_EN defined: round-robin arbitration. A 2-bit last-grant pointer makes the most recently granted requester lowest priority, and rotation order is D → I → MU. The pointer resets to MU, so D wins first.
- Without the macro: fixed priority D > I > MU and no pointer register.

Decomposition:
- Package sdram_arb_pkg:
  - FSM state encodings ST_IDLE, ST_ISSUE, ST_WAIT.
  - Requester IDs REQ_D=2'd0, REQ_I=2'd1, REQ_MU=2'd2.
  - Default ADDR_BITS and DATA_BITS.
- Sub-module sdram_arb_req_slot, instantiated three times: capture regs, pending/ready, q register and done pulse.
- Top level: FSM, grant logic and output mux.

Test Plan:
- Reset held 3 cycles, then released → all outputs 0 during reset; all ready=1 one cycle after release; sdram_start stays 0.
- I read addr 0x000010 with a 1-cycle-latency memory returning 0xDEADBEEF → one sdram_start pulse with addr 0x000010 and we=0; bus_i_sdram_done one cycle with q=0xDEADBEEF; D and MU outputs unchanged.
- D write (addr 0x000100, data 0x12345678) and I read (0x000004) started in the same cycle, fixed priority → D issued first with we=1; I issued after D's done; two separate done pulses.
- With SDRAM_ARB_RR_EN, D, I and MU all restarting immediately after every done for 9 transactions → grant order D,I,MU repeating; without the macro, MU never granted while D/I keep requesting.
- reset asserted in WAIT, with sdram_done arriving 2 cycles later → no requester done pulse; FSM in IDLE; pending cleared.
- D start while bus_d_sdram_ready=0 → request dropped and assertion fires; exactly one transaction issued.
